eth_phy_10g_link_ctrl: RTL and testbench
========================================

ETH_PHY_10G_LINK_CTRL -- requirements
Module: eth_phy_10g_link_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles allowed in WAIT_LOCK before a retry.
REQ-002 SHALL have parameter STATUS_TIMEOUT, default 4096: cycles allowed in WAIT_STATUS before a retry.
REQ-003 SHALL have parameter RESET_CYCLES, default 4: width in cycles of each serdes_rx_reset_req pulse.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 16: cycles rx_status must stay 1 before the link is declared up.
REQ-005 SHALL have parameter MAX_RETRIES, default 7: failed attempts allowed before FAULT.
REQ-006 SHALL have one clock and one reset; reset is asynchronous and active-high: rx_clk in 1, rx_rst in 1.
REQ-007 SHALL have inputs enable 1 (run sequencer), clear_counters 1 (zero statistics).
REQ-008 SHALL have inputs rx_block_lock 1, rx_high_ber 1, rx_status 1, rx_bad_block 1 (per-cycle pulse), all from the PHY RX path.
REQ-009 SHALL have outputs serdes_rx_reset_req 1, link_up 1, link_fault 1, state 3 (encoded state), retry_count 4.
REQ-010 SHALL have outputs reset_count 16 (reset pulses issued), bad_block_count 16 (bad blocks while up).

Function
REQ-011 SHALL encode states as IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_STATUS=3, HOLDOFF=4, UP=5, FAULT=6.
REQ-012 SHALL register all outputs; they update on the same rx_clk edge as the state register, with no extra latency.
REQ-013 SHALL give enable=0 the highest priority: any state goes to IDLE on the next edge, and retry_count clears to 0.
REQ-014 In IDLE, with enable=1, SHALL go to RESET.
REQ-015 In RESET, SHALL hold serdes_rx_reset_req=1 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
REQ-016 SHALL increment reset_count by 1 on each entry to RESET.
REQ-017 SHALL use one 16-bit timer that clears to 0 on every state change and increments by 1 each cycle the state is unchanged.
REQ-018 In WAIT_LOCK: rx_block_lock=1 -> WAIT_STATUS; otherwise, when timer==LOCK_TIMEOUT-1 -> retry.
REQ-019 In WAIT_STATUS, in priority order:
- rx_block_lock=0 -> WAIT_LOCK;
- rx_status=1 and rx_high_ber=0 -> HOLDOFF;
- timer==STATUS_TIMEOUT-1 -> retry.
REQ-020 Retry: if retry_count==MAX_RETRIES, go to FAULT; otherwise increment retry_count and go to RESET.
REQ-021 In HOLDOFF:
- rx_status=0 or rx_high_ber=1 -> WAIT_STATUS;
- rx_block_lock=0 -> WAIT_LOCK;
- timer==HOLDOFF_CYCLES-1 with status still good -> UP, and retry_count clears to 0.
REQ-022 In UP, link_up=1; in all other states link_up=0.
REQ-023 In UP: rx_block_lock=0 -> RESET (retry_count not incremented); otherwise rx_status=0 or rx_high_ber=1 -> WAIT_STATUS.
REQ-024 In FAULT, link_fault=1 and no reset requests are issued; the only exit is enable=0 -> IDLE.
REQ-025 SHALL increment bad_block_count only on cycles where state==UP and rx_bad_block=1.
REQ-026 SHALL saturate reset_count and bad_block_count at 16'hFFFF; neither wraps.
REQ-027 On clear_counters=1, SHALL zero both counters on the next edge; clear wins over a simultaneous increment (result is 0).
REQ-028 clear_counters SHALL NOT affect state, timer or retry_count.
REQ-029 SHALL treat input glitches inside HOLDOFF as a restart: re-entering HOLDOFF restarts the timer at 0.

Reset
REQ-030 rx_rst=1 SHALL asynchronously force state=IDLE, timer=0, retry_count=0, reset_count=0, bad_block_count=0, serdes_rx_reset_req=0, link_up=0, link_fault=0.
REQ-031 Reset mid-pulse SHALL drop serdes_rx_reset_req immediately, without waiting for a clock edge.
REQ-032 After rx_rst is released, the first transition SHALL occur on the first rx_clk edge with enable=1.

Verification (LOCK_TIMEOUT=16, STATUS_TIMEOUT=32, RESET_CYCLES=4, HOLDOFF_CYCLES=8, MAX_RETRIES=2)
REQ-033 Happy path:
- stimulus: enable=1, rx_block_lock=1 after 3 cycles in WAIT_LOCK, rx_status=1;
- required: serdes_rx_reset_req high exactly 4 cycles, link_up=1 after 8 HOLDOFF cycles, reset_count=1, retry_count=0.
REQ-034 Lock never asserted:
- stimulus: enable=1, rx_block_lock held 0;
- required: three reset pulses, 16 cycles apart in WAIT_LOCK, then state=6, link_fault=1, retry_count=2, reset_count=3.
REQ-035 HOLDOFF glitch:
- stimulus: rx_status drops for 1 cycle at HOLDOFF timer=5;
- required: state returns to 3, then re-enters 4 with timer=0; link_up is delayed by a full 8 cycles.
REQ-036 Loss while up:
- stimulus in UP: rx_high_ber=1 -> required: state=3, link_up=0 next edge;
- stimulus in UP: rx_block_lock=0 -> required: state=1, serdes_rx_reset_req=1, retry_count unchanged.
REQ-037 Counters:
- stimulus: 5 rx_bad_block pulses in UP and 2 in WAIT_STATUS -> required: bad_block_count=5;
- stimulus: clear_counters coincident with a bad block -> required: bad_block_count=0;
- stimulus: preload to FFFF -> required: stays FFFF.
REQ-038 Asynchronous reset:
- stimulus: rx_rst asserted between clock edges during RESET;
- required: serdes_rx_reset_req=0 and state=0 before the next rx_clk edge; all counters=0.

Source files
------------

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY RX link bring-up sequencer: serdes reset, lock/status
// qualification, holdoff debounce, bounded retries and link statistics.
module eth_phy_10g_link_ctrl #(
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STATUS_TIMEOUT = 4096,
    parameter int RESET_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int MAX_RETRIES    = 7
) (
    input  logic        rx_clk,
    input  logic        rx_rst,
    input  logic        enable,
    input  logic        clear_counters,
    input  logic        rx_block_lock,
    input  logic        rx_high_ber,
    input  logic        rx_status,
    input  logic        rx_bad_block,
    output logic        serdes_rx_reset_req,
    output logic        link_up,
    output logic        link_fault,
    output logic [2:0]  state,
    output logic [3:0]  retry_count,
    output logic [15:0] reset_count,
    output logic [15:0] bad_block_count
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RESET       = 3'd1,
        WAIT_LOCK   = 3'd2,
        WAIT_STATUS = 3'd3,
        HOLDOFF     = 3'd4,
        UP          = 3'd5,
        FAULT       = 3'd6
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STATUS_LAST = 16'(STATUS_TIMEOUT - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLDOFF_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

    state_t      cur;
    state_t      nxt;
    logic [15:0] timer;
    logic [3:0]  retry_nxt;
    logic        retry;
    logic        status_ok;

    always_comb begin
        nxt       = cur;
        retry_nxt = retry_count;
        retry     = 1'b0;
        status_ok = rx_status && !rx_high_ber;
        if (!enable) begin
            nxt       = IDLE;
            retry_nxt = '0;
        end else begin
            case (cur)
                IDLE: nxt = RESET;
                RESET: begin
                    if (timer == RST_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (rx_block_lock) nxt = WAIT_STATUS;
                    else if (timer == LOCK_LAST) retry = 1'b1;
                end
                WAIT_STATUS: begin
                    if (!rx_block_lock) nxt = WAIT_LOCK;
                    else if (status_ok) nxt = HOLDOFF;
                    else if (timer == STATUS_LAST) retry = 1'b1;
                end
                HOLDOFF: begin
                    if (!status_ok) nxt = WAIT_STATUS;
                    else if (!rx_block_lock) nxt = WAIT_LOCK;
                    else if (timer == HOLD_LAST) begin
                        nxt       = UP;
                        retry_nxt = '0;
                    end
                end
                UP: begin
                    // Lost lock while up restarts the serdes without charging a retry
                    if (!rx_block_lock) nxt = RESET;
                    else if (!status_ok) nxt = WAIT_STATUS;
                end
                FAULT: nxt = FAULT;
                default: nxt = IDLE;
            endcase
            if (retry) begin
                if (retry_count == RETRY_MAX) begin
                    nxt = FAULT;
                end else begin
                    nxt       = RESET;
                    retry_nxt = retry_count + 4'd1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they align with the state register
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            cur                 <= IDLE;
            timer               <= '0;
            retry_count         <= '0;
            reset_count         <= '0;
            bad_block_count     <= '0;
            serdes_rx_reset_req <= 1'b0;
            link_up             <= 1'b0;
            link_fault          <= 1'b0;
        end else begin
            cur                 <= nxt;
            timer               <= (nxt != cur) ? 16'd0 : timer + 16'd1;
            retry_count         <= retry_nxt;
            serdes_rx_reset_req <= (nxt == RESET);
            link_up             <= (nxt == UP);
            link_fault          <= (nxt == FAULT);
            if (clear_counters) begin
                reset_count     <= '0;
                bad_block_count <= '0;
            end else begin
                if (nxt == RESET && cur != RESET && reset_count != 16'hFFFF)
                    reset_count <= reset_count + 16'd1;
                if (cur == UP && rx_bad_block && bad_block_count != 16'hFFFF)
                    bad_block_count <= bad_block_count + 16'd1;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Directed bench for the 10G PHY link sequencer with shortened timeouts.
module tb_eth_phy_10g_link_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        lock = 1'b0;
    logic        ber = 1'b0;
    logic        status = 1'b0;
    logic        bad = 1'b0;
    logic        req;
    logic        link_up;
    logic        fault;
    logic [2:0]  state;
    logic [3:0]  retry;
    logic [15:0] rcnt;
    logic [15:0] bcnt;

    int errors = 0;
    int checks = 0;

    eth_phy_10g_link_ctrl #(
        .LOCK_TIMEOUT(16),
        .STATUS_TIMEOUT(32),
        .RESET_CYCLES(4),
        .HOLDOFF_CYCLES(8),
        .MAX_RETRIES(2)
    ) dut (
        .rx_clk(clk),
        .rx_rst(rst),
        .enable(enable),
        .clear_counters(clear),
        .rx_block_lock(lock),
        .rx_high_ber(ber),
        .rx_status(status),
        .rx_bad_block(bad),
        .serdes_rx_reset_req(req),
        .link_up(link_up),
        .link_fault(fault),
        .state(state),
        .retry_count(retry),
        .reset_count(rcnt),
        .bad_block_count(bcnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input logic [2:0] s, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (state == s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        enable = 0; clear = 0; lock = 0; ber = 0; status = 0; bad = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        enable = 0; lock = 0; status = 0;
        rst = 1;
        #3;
        checks++;
        if (state !== 3'd0 || req !== 1'b0 || link_up !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d req=%b up=%b fault=%b want 0 0 0 0",
                     state, req, link_up, fault);
        end
        checks++;
        if (retry !== 4'd0 || rcnt !== 16'd0 || bcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: retry=%0d rcnt=%0d bcnt=%0d want 0", retry, rcnt, bcnt);
        end
        tick();
        tick();
        rst = 0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: state=%0d want 0", state);
        end
        enable = 1;
        tick();
        checks++;
        if (state !== 3'd1 || req !== 1'b1 || rcnt !== 16'd1) begin
            errors++;
            $display("FAIL first_enable: state=%0d req=%b rcnt=%0d want 1 1 1", state, req, rcnt);
        end
    endtask

    task automatic test_happy();
        int cnt;
        int h;
        do_reset();
        enable = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req) cnt++;
            if (state == 3'd2) break;
        end
        checks++;
        if (cnt != 4 || state !== 3'd2 || rcnt !== 16'd1) begin
            errors++;
            $display("FAIL happy_pulse: width=%0d state=%0d rcnt=%0d want 4 2 1", cnt, state, rcnt);
        end
        repeat (2) tick();
        lock = 1; status = 1;
        tick();
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL happy_wait_status: state=%0d want 3", state);
        end
        tick();
        checks++;
        if (state !== 3'd4 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL happy_holdoff: state=%0d up=%b want 4 0", state, link_up);
        end
        h = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == 3'd4) h++;
            else break;
        end
        checks++;
        if (h != 8 || state !== 3'd5 || link_up !== 1'b1) begin
            errors++;
            $display("FAIL happy_up: holdoff=%0d state=%0d up=%b want 8 5 1", h, state, link_up);
        end
        checks++;
        if (rcnt !== 16'd1 || retry !== 4'd0) begin
            errors++;
            $display("FAIL happy_counts: rcnt=%0d retry=%0d want 1 0", rcnt, retry);
        end
    endtask

    task automatic test_lock_timeout();
        int pulses;
        int wl;
        logic prev;
        logic leak;
        do_reset();
        enable = 1;
        pulses = 0; wl = 0; prev = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (req && !prev) pulses++;
            prev = req;
            if (state == 3'd2) begin
                wl++;
            end else if (wl != 0) begin
                checks++;
                if (wl != 16) begin
                    errors++;
                    $display("FAIL lock_wait_len: got %0d want 16", wl);
                end
                wl = 0;
            end
            if (state == 3'd6) break;
        end
        checks++;
        if (state !== 3'd6 || fault !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL lock_fault: state=%0d fault=%b req=%b want 6 1 0", state, fault, req);
        end
        checks++;
        if (pulses != 3 || retry !== 4'd2 || rcnt !== 16'd3) begin
            errors++;
            $display("FAIL lock_counts: pulses=%0d retry=%0d rcnt=%0d want 3 2 3",
                     pulses, retry, rcnt);
        end
        leak = 0;
        repeat (10) begin
            tick();
            if (req || state != 3'd6) leak = 1;
        end
        checks++;
        if (leak !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: got leak=%b want 0", leak);
        end
        enable = 0;
        tick();
        checks++;
        if (state !== 3'd0 || fault !== 1'b0 || retry !== 4'd0) begin
            errors++;
            $display("FAIL fault_exit: state=%0d fault=%b retry=%0d want 0 0 0", state, fault, retry);
        end
    endtask

    task automatic test_holdoff_glitch();
        int n;
        int h;
        do_reset();
        lock = 1; status = 1; enable = 1;
        run_until(3'd4, 40, n);
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL glitch_reach: got %0d cycles want 7", n);
        end
        repeat (5) tick();
        status = 0;
        tick();
        status = 1;
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL glitch_drop: state=%0d want 3", state);
        end
        tick();
        checks++;
        if (state !== 3'd4 || dut.timer !== 16'd0) begin
            errors++;
            $display("FAIL glitch_reenter: state=%0d timer=%0d want 4 0", state, dut.timer);
        end
        h = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state == 3'd4) h++;
            else break;
        end
        checks++;
        if (h != 8 || link_up !== 1'b1) begin
            errors++;
            $display("FAIL glitch_up: holdoff=%0d up=%b want 8 1", h, link_up);
        end
    endtask

    task automatic test_loss_while_up();
        int n;
        ber = 1;
        tick();
        ber = 0;
        checks++;
        if (state !== 3'd3 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL loss_ber: state=%0d up=%b want 3 0", state, link_up);
        end
        run_until(3'd5, 20, n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL loss_recover: got %0d cycles want 9", n);
        end
        lock = 0;
        tick();
        checks++;
        if (state !== 3'd1 || req !== 1'b1 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL loss_lock: state=%0d req=%b up=%b want 1 1 0", state, req, link_up);
        end
        checks++;
        if (retry !== 4'd0 || rcnt !== 16'd2) begin
            errors++;
            $display("FAIL loss_counts: retry=%0d rcnt=%0d want 0 2", retry, rcnt);
        end
    endtask

    task automatic test_counters();
        int n;
        do_reset();
        lock = 1; status = 1; enable = 1;
        run_until(3'd5, 60, n);
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL cnt_reach_up: got %0d cycles want 15", n);
        end
        repeat (5) begin
            bad = 1; tick();
            bad = 0; tick();
        end
        checks++;
        if (bcnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_bad_up: got %0d want 5", bcnt);
        end
        status = 0;
        tick();
        repeat (2) begin
            bad = 1; tick();
            bad = 0; tick();
        end
        checks++;
        if (state !== 3'd3 || bcnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_bad_ws: state=%0d bcnt=%0d want 3 5", state, bcnt);
        end
        status = 1;
        run_until(3'd5, 20, n);
        clear = 1; bad = 1;
        tick();
        clear = 0;
        checks++;
        if (bcnt !== 16'd0 || rcnt !== 16'd0 || state !== 3'd5) begin
            errors++;
            $display("FAIL cnt_clear: bcnt=%0d rcnt=%0d state=%0d want 0 0 5", bcnt, rcnt, state);
        end
        repeat (65535) tick();
        checks++;
        if (bcnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_fill: got %h want ffff", bcnt);
        end
        repeat (3) tick();
        bad = 0;
        checks++;
        if (bcnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h want ffff", bcnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1;
        tick();
        tick();
        checks++;
        if (state !== 3'd1 || req !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: state=%0d req=%b want 1 1", state, req);
        end
        #3;
        rst = 1;
        #1;
        checks++;
        if (req !== 1'b0 || state !== 3'd0 || rcnt !== 16'd0 || bcnt !== 16'd0 || retry !== 4'd0) begin
            errors++;
            $display("FAIL ar_async: req=%b state=%0d rcnt=%0d bcnt=%0d retry=%0d want all 0",
                     req, state, rcnt, bcnt, retry);
        end
        #1;
        rst = 0;
        tick();
        checks++;
        if (state !== 3'd1 || rcnt !== 16'd1) begin
            errors++;
            $display("FAIL ar_restart: state=%0d rcnt=%0d want 1 1", state, rcnt);
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_lock_timeout();
        test_holdoff_glitch();
        test_loss_while_up();
        test_counters();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
